pipeline_control: RTL

PIPELINE_CONTROL -- requirements
Module: pipeline_control

---
 rtl/pipeline_control.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/pipeline_control.sv
// Pipeline sequencing controller: arbitrates memory stalls, branch redirects and
// load-use hazards into per-stage enables, flushes and a NOP-bubble select.
module pipeline_control #(
   parameter int FLUSH_CYCLES = 1,
   parameter int MEM_TIMEOUT  = 64,
   parameter int CNT_W        = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load_use_hazard,
   input  logic             mem_req,
   input  logic             mem_ready,
   input  logic             bru_redirect,
   output logic             fetch_en,
   output logic             decode_en,
   output logic             ex_en,
   output logic             ex_bubble,
   output logic             flush_fe,
   output logic             flush_dc,
   output logic [1:0]       ctl_state,
   output logic [CNT_W-1:0] stall_cycles,
   output logic             mem_timeout
);

   typedef enum logic [1:0] {
      RUN      = 2'b00,
      MEM_WAIT = 2'b01,
      FLUSH    = 2'b10,
      HALT     = 2'b11
   } ctlState_e;

   localparam logic [7:0] TimeoutLimit = 8'(MEM_TIMEOUT);
   localparam logic [3:0] FlushLoad    = 4'(FLUSH_CYCLES);

   ctlState_e        state_q, state_d;
   ctlState_e        stateEff;
   logic [7:0]       waitCnt_q, waitCnt_d;
   logic [3:0]       flushCnt_q, flushCnt_d;
   logic [CNT_W-1:0] stallCnt_q, stallCnt_d;
   logic             memTimeout_q, memTimeout_d;

   logic             luEff, memReqEff, memReadyEff, redirectEff;
   logic             stallCount;

   // While reset is held the controller must look like an idle RUN state.
   assign stateEff    = rst_n ? state_q : RUN;
   assign luEff       = rst_n & load_use_hazard;
   assign memReqEff   = rst_n & mem_req;
   assign memReadyEff = rst_n & mem_ready;
   assign redirectEff = rst_n & bru_redirect;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q      <= RUN;
         waitCnt_q    <= '0;
         flushCnt_q   <= '0;
         stallCnt_q   <= '0;
         memTimeout_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         waitCnt_q    <= waitCnt_d;
         flushCnt_q   <= flushCnt_d;
         stallCnt_q   <= stallCnt_d;
         memTimeout_q <= memTimeout_d;
      end
   end

   always_comb begin
      state_d      = stateEff;
      waitCnt_d    = waitCnt_q;
      flushCnt_d   = flushCnt_q;
      memTimeout_d = memTimeout_q;
      fetch_en     = 1'b0;
      decode_en    = 1'b0;
      ex_en        = 1'b0;
      ex_bubble    = 1'b0;
      flush_fe     = 1'b0;
      flush_dc     = 1'b0;

      unique case (stateEff)
         RUN: begin
            if (memReqEff && !memReadyEff) begin
               state_d   = MEM_WAIT;
               waitCnt_d = 8'd1;
            end else if (redirectEff) begin
               fetch_en   = 1'b1;
               decode_en  = 1'b1;
               ex_en      = 1'b1;
               flush_fe   = 1'b1;
               flush_dc   = 1'b1;
               state_d    = FLUSH;
               flushCnt_d = FlushLoad;
            end else if (luEff) begin
               ex_en     = 1'b1;
               ex_bubble = 1'b1;
            end else begin
               fetch_en  = 1'b1;
               decode_en = 1'b1;
               ex_en     = 1'b1;
            end
         end

         MEM_WAIT: begin
            // On the ready cycle the bundle leaves EX, so redirect/load-use apply as in RUN.
            if (!memReadyEff) begin
               if (waitCnt_q == TimeoutLimit) begin
                  state_d      = HALT;
                  memTimeout_d = 1'b1;
               end else begin
                  waitCnt_d = waitCnt_q + 8'd1;
               end
            end else if (redirectEff) begin
               fetch_en   = 1'b1;
               decode_en  = 1'b1;
               ex_en      = 1'b1;
               flush_fe   = 1'b1;
               flush_dc   = 1'b1;
               state_d    = FLUSH;
               flushCnt_d = FlushLoad;
            end else if (luEff) begin
               ex_en     = 1'b1;
               ex_bubble = 1'b1;
               state_d   = RUN;
            end else begin
               fetch_en  = 1'b1;
               decode_en = 1'b1;
               ex_en     = 1'b1;
               state_d   = RUN;
            end
         end

         FLUSH: begin
            fetch_en  = 1'b1;
            decode_en = 1'b1;
            ex_en     = 1'b1;
            flush_dc  = 1'b1;
            if (flushCnt_q <= 4'd1) begin
               state_d    = RUN;
               flushCnt_d = 4'd0;
            end else begin
               flushCnt_d = flushCnt_q - 4'd1;
            end
         end

         HALT: begin
            state_d = HALT;
         end

         default: begin
            state_d = RUN;
         end
      endcase
   end

   // HALT is excluded so the count freezes at the value it had on timeout.
   assign stallCount = !fetch_en && ((state_q == RUN) || (state_q == MEM_WAIT));

   always_comb begin
      stallCnt_d = stallCnt_q;
      if (stallCount && (stallCnt_q != {CNT_W{1'b1}})) begin
         stallCnt_d = stallCnt_q + CNT_W'(1);
      end
   end

   assign ctl_state    = stateEff;
   assign stall_cycles = stallCnt_q;
   assign mem_timeout  = memTimeout_q;

endmodule
